// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and state encoding for the instruction memory loader.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} imem_state_t;
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: DEPTH x INSTR_W store, one sync write port, combinational fetch read.
// INSTR_MEM_READBACK_EN adds a second combinational debug read port.
module instr_mem_array #(
  parameter int DEPTH = 256,
  parameter int INSTR_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] fetch_data
`ifdef INSTR_MEM_READBACK_EN
  , input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [INSTR_W-1:0] dbg_data
`endif
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign fetch_data = mem[fetch_addr];
`ifdef INSTR_MEM_READBACK_EN
  assign dbg_data = mem[dbg_addr];
`endif
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loadable program store with valid/ready burst loading and zero-latency fetch.
// INSTR_MEM_READBACK_EN adds dbg_addr/dbg_data/dbg_valid combinational readback.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_C),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done,
  output logic [ADDR_W:0]    load_count,
  output logic               load_ovf,
  output logic               busy,
  input  logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               fetch_err
`ifdef INSTR_MEM_READBACK_EN
  , input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [INSTR_W-1:0] dbg_data,
  output logic               dbg_valid
`endif
);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  imem_state_t        state;
  logic [DEPTH-1:0]   vmap;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  idx;
  logic [INSTR_W-1:0] word;
  logic               accept;
  assign accept = load_valid && load_ready;
  assign busy = state == LOAD;
  assign idx = pc[ADDR_W+1:2];
  instr_mem_array #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) u_array (
    .clk(clk), .we(accept), .waddr(ptr), .wdata(load_data),
    .fetch_addr(idx), .fetch_data(word)
`ifdef INSTR_MEM_READBACK_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );
`ifdef INSTR_MEM_READBACK_EN
  assign dbg_valid = vmap[dbg_addr];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vmap <= '0;
      ptr <= '0;
      load_ready <= 1'b0;
      load_done <= 1'b0;
      load_count <= '0;
      load_ovf <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          state <= LOAD;
          load_ready <= 1'b1;
          ptr <= load_base;
          load_count <= '0;
          load_ovf <= 1'b0;
        end
        LOAD: if (accept) begin
          vmap[ptr] <= 1'b1;
          ptr <= ptr + 1'b1;
          load_count <= load_count + 1'b1;
          // a full-depth burst without load_last closes itself as an overflow
          if (load_last || load_count == LAST_CNT) begin
            state <= DONE;
            load_ready <= 1'b0;
            load_done <= 1'b1;
            load_ovf <= !load_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  always_comb begin
    fetch_err = |pc[1:0] || |(pc >> (ADDR_W + 2)) || !vmap[idx] || state == LOAD;
    instr = fetch_err ? NOP_INSTR : word;
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of loading, fetch legality, wrap, overflow and reset.
module tb_instr_mem_loader;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, rst_n = 0;
  logic load_start = 0, load_valid = 0, load_last = 0;
  logic [AW-1:0] load_base = '0;
  logic [31:0] load_data = '0, pc = '0, instr;
  logic load_ready, load_done, load_ovf, busy, fetch_err;
  logic [AW:0] load_count;
  int errors = 0, checks = 0, pulses;
`ifdef INSTR_MEM_READBACK_EN
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0] dbg_data;
  logic dbg_valid;
`endif

  instr_mem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_count(load_count),
    .load_ovf(load_ovf), .busy(busy), .pc(pc), .instr(instr), .fetch_err(fetch_err)
`ifdef INSTR_MEM_READBACK_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_valid(dbg_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] base);
    load_start = 1; load_base = base;
    tick();
    load_start = 0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    tick();
    load_valid = 0; load_last = 0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e);
    pc = a;
    #1;
    chk({tag, "_instr"}, instr, exp_i);
    chk({tag, "_err"}, fetch_err, exp_e);
  endtask

  initial begin
    #1;
    fetch("rst_pc0", 0, 0, 1);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", load_count, 0);
    chk("rst_ovf", load_ovf, 0);
    chk("rst_done", load_done, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // basic 4-word program at base 0
    start(0);
    chk("b1_ready", load_ready, 1);
    chk("b1_busy", busy, 1);
    beat(32'h2001_0005, 0);
    beat(32'h2002_000A, 0);
    beat(32'h0022_1820, 0);
    beat(32'h0800_0000, 1);
    chk("b1_done", load_done, 1);
    chk("b1_count", load_count, 4);
    chk("b1_ready_off", load_ready, 0);
    tick();
    chk("b1_done_pulse", load_done, 0);
    chk("b1_busy_off", busy, 0);
    fetch("b1_pc8", 8, 32'h0022_1820, 0);
    fetch("b1_pc16", 16, 0, 1);
    fetch("b1_pc0", 0, 32'h2001_0005, 0);
    fetch("b1_pc12", 12, 32'h0800_0000, 0);
`ifdef INSTR_MEM_READBACK_EN
    dbg_addr = 3; #1;
    chk("dbg3_data", dbg_data, 32'h0800_0000);
    chk("dbg3_valid", dbg_valid, 1);
    dbg_addr = 10; #1;
    chk("dbg10_valid", dbg_valid, 0);
`endif

    // stalled burst at base 4, with an ignored load_start mid-burst
    start(4);
    beat(32'h1111_1111, 0);
    beat(32'h2222_2222, 0);
    for (int i = 0; i < 3; i++) begin
      load_start = (i == 1); load_base = 9;
      fetch("stall_pc0", 0, 0, 1);
      chk("stall_busy", busy, 1);
      chk("stall_count", load_count, 2);
      tick();
    end
    load_start = 0;
    beat(32'h3333_3333, 1);
    chk("stall_done", load_done, 1);
    chk("stall_count_end", load_count, 3);
    tick();
    fetch("stall_w4", 16, 32'h1111_1111, 0);
    fetch("stall_w5", 20, 32'h2222_2222, 0);
    fetch("stall_w6", 24, 32'h3333_3333, 0);
    fetch("stall_w9", 36, 0, 1);
    fetch("stall_keep_w0", 0, 32'h2001_0005, 0);

    // wrap, with valid asserted alongside load_start (must not be taken)
    load_start = 1; load_base = 15; load_valid = 1; load_data = 32'hDEAD_BEEF;
    tick();
    load_start = 0; load_valid = 0;
    chk("wrap_count0", load_count, 0);
    chk("wrap_ready", load_ready, 1);
    beat(32'hAAAA_AAAA, 0);
    beat(32'hBBBB_BBBB, 1);
    tick();
    fetch("wrap_w15", 60, 32'hAAAA_AAAA, 0);
    fetch("wrap_w0", 0, 32'hBBBB_BBBB, 0);
    fetch("wrap_w1", 4, 32'h2002_000A, 0);

    // illegal fetch addresses
    fetch("ill_misalign", 32'h0000_0002, 0, 1);
    fetch("ill_range", 4 * DEPTH, 0, 1);
    fetch("ill_high", 32'h8000_0000, 0, 1);

    // overflow: DEPTH+3 beats, never load_last
    start(0);
    pulses = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      load_valid = 1; load_data = 32'h100 + i; load_last = 0;
      #1;
      chk($sformatf("ovf_ready%0d", i), load_ready, i < DEPTH);
      tick();
      if (load_done) pulses++;
      if (i == DEPTH - 1) begin
        chk("ovf_flag", load_ovf, 1);
        chk("ovf_count", load_count, DEPTH);
      end
    end
    load_valid = 0;
    chk("ovf_pulses", pulses, 1);
    chk("ovf_sticky", load_ovf, 1);
    chk("ovf_count_hold", load_count, DEPTH);
    fetch("ovf_w0", 0, 32'h100, 0);
    fetch("ovf_w15", 60, 32'h10F, 0);

    // reset in the middle of a burst
    start(2);
    beat(32'h5555_5555, 0);
    beat(32'h6666_6666, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", load_ready, 0);
    chk("rst_mid_count", load_count, 0);
    fetch("rst_mid_pc0", 0, 0, 1);
    fetch("rst_mid_pc8", 8, 0, 1);
    tick();
    rst_n = 1;
    tick();
    fetch("rst_after_pc60", 60, 0, 1);
    chk("rst_after_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
